// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: next-PC select codes,
// fetch FSM state encodings and the default reset PC.
package inst_fetch_unit_pkg;

  typedef enum logic [1:0] {
    NPC_INC    = 2'b00,
    NPC_BRANCH = 2'b01,
    NPC_JUMP   = 2'b10,
    NPC_REG    = 2'b11
  } npc_sel_e;

  typedef enum logic [1:0] {
    IFU_IDLE  = 2'b00,
    IFU_WAIT  = 2'b01,
    IFU_FAULT = 2'b10
  } ifu_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_1000;
  localparam int          JUMP_W           = 26;  // jump target field width
  localparam int          IMM_W            = 16;  // branch offset field width

endpackage

// File: rtl/inst_fetch_unit_npc_calc.sv
// Combinational next-PC selection: increment, PC-relative branch, region jump
// or register target. All arithmetic wraps modulo 2^DATA_WIDTH.
module npc_calc
  import inst_fetch_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [JUMP_W-1:0]     instruction,  // only the jump/offset fields matter here
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic [1:0]            npc_sel,
  output logic [DATA_WIDTH-1:0] next_pc
);

  logic [DATA_WIDTH-1:0] pc_inc;
  logic [DATA_WIDTH-1:0] imm_ext;

  // NOTE: every signal driven here gets a value on every path; a missing
  // branch would silently infer a latch.
  always_comb begin
    pc_inc  = pc + DATA_WIDTH'(1);
    imm_ext = {{(DATA_WIDTH-IMM_W){instruction[IMM_W-1]}}, instruction[IMM_W-1:0]};
    case (npc_sel_e'(npc_sel))
      NPC_INC:    next_pc = pc_inc;
      NPC_BRANCH: next_pc = pc_inc + imm_ext;
      NPC_JUMP:   next_pc = {pc[DATA_WIDTH-1:JUMP_W], instruction};
      default:    next_pc = rs_data;
    endcase
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns PC and instruction register, reads memory with
// a wait-state handshake and a timeout that parks the unit in a sticky fault.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int                   ADDR_WIDTH = 26,
  parameter int                   DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int                   TIMEOUT    = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FETCH_REQ,
  input  logic                  PC_LOAD,
  input  logic [1:0]            NPC_SEL,
  input  logic [DATA_WIDTH-1:0] RS_DATA,
  input  logic [DATA_WIDTH-1:0] MEM_DATA,
  input  logic                  MEM_READY,
  output logic                  MEM_READ,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [DATA_WIDTH-1:0] INSTRUCTION,
  output logic [DATA_WIDTH-1:0] PC,
  output logic                  INST_VALID,
  output logic                  BUSY,
  output logic                  FAULT
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  ifu_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic                  pend_valid_q;
  logic [1:0]            pend_sel_q;
  logic [DATA_WIDTH-1:0] pend_rs_q;

  logic                  capture;
  logic                  load_now;
  logic [1:0]            load_sel;
  logic [DATA_WIDTH-1:0] load_rs;
  logic [DATA_WIDTH-1:0] next_pc;

  // A fresh PC_LOAD in IDLE takes priority over a load deferred from WAIT.
  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    load_now = 1'b0;
    load_sel = NPC_SEL;
    load_rs  = RS_DATA;
    case (state_q)
      IFU_IDLE: begin
        if (PC_LOAD) begin
          load_now = 1'b1;
        end else if (pend_valid_q) begin
          load_now = 1'b1;
          load_sel = pend_sel_q;
          load_rs  = pend_rs_q;
        end
        if (FETCH_REQ) state_d = IFU_WAIT;
      end
      IFU_WAIT: begin
        if (MEM_READY) begin
          capture = 1'b1;
          state_d = IFU_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = IFU_FAULT;
        end
      end
      IFU_FAULT: state_d = IFU_FAULT;
      default:   state_d = IFU_IDLE;
    endcase
  end

  npc_calc #(.DATA_WIDTH(DATA_WIDTH)) u_npc_calc (
    .pc          (PC),
    .instruction (INSTRUCTION[JUMP_W-1:0]),
    .rs_data     (load_rs),
    .npc_sel     (load_sel),
    .next_pc     (next_pc)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IFU_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      PC           <= RESET_PC;
      INSTRUCTION  <= '0;
      MEM_ADDR     <= '0;
      INST_VALID   <= 1'b0;
      cnt_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_sel_q   <= '0;
      pend_rs_q    <= '0;
    end else begin
      INST_VALID <= capture;
      if (load_now) PC <= next_pc;
      if (capture) INSTRUCTION <= MEM_DATA;

      // The fetch address follows a same-cycle PC update.
      if (state_q == IFU_IDLE && FETCH_REQ) begin
        MEM_ADDR <= load_now ? next_pc[ADDR_WIDTH-1:0] : PC[ADDR_WIDTH-1:0];
        cnt_q    <= '0;
      end else if (state_q == IFU_WAIT && !MEM_READY) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if (state_q == IFU_WAIT) begin
        if (PC_LOAD) begin
          pend_valid_q <= 1'b1;
          pend_sel_q   <= NPC_SEL;
          pend_rs_q    <= RS_DATA;
        end
      end else begin
        pend_valid_q <= 1'b0;
      end
    end
  end

  assign MEM_READ = (state_q == IFU_WAIT);
  assign BUSY     = (state_q == IFU_WAIT);
  assign FAULT    = (state_q == IFU_FAULT);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios plus randomized
// fetch/load traffic compared against an architectural PC/IR model.
module tb_inst_fetch_unit;

  localparam int          AW  = 26;
  localparam int          DW  = 32;
  localparam int          TO  = 16;
  localparam logic [31:0] RPC = 32'h0000_1000;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          FETCH_REQ = 1'b0;
  logic          PC_LOAD = 1'b0;
  logic [1:0]    NPC_SEL = 2'b00;
  logic [DW-1:0] RS_DATA = '0;
  logic [DW-1:0] MEM_DATA = '0;
  logic          MEM_READY = 1'b0;
  logic          MEM_READ;
  logic [AW-1:0] MEM_ADDR;
  logic [DW-1:0] INSTRUCTION;
  logic [DW-1:0] PC;
  logic          INST_VALID;
  logic          BUSY;
  logic          FAULT;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ir;

  inst_fetch_unit #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RESET_PC   (RPC),
    .TIMEOUT    (TO)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .FETCH_REQ   (FETCH_REQ),
    .PC_LOAD     (PC_LOAD),
    .NPC_SEL     (NPC_SEL),
    .RS_DATA     (RS_DATA),
    .MEM_DATA    (MEM_DATA),
    .MEM_READY   (MEM_READY),
    .MEM_READ    (MEM_READ),
    .MEM_ADDR    (MEM_ADDR),
    .INSTRUCTION (INSTRUCTION),
    .PC          (PC),
    .INST_VALID  (INST_VALID),
    .BUSY        (BUSY),
    .FAULT       (FAULT)
  );

  always #5 CLK = ~CLK;

  // Architectural next-PC rule written as plain integer arithmetic.
  function automatic logic [31:0] ref_npc(input logic [1:0] sel, input logic [31:0] pc,
                                          input logic [31:0] ir, input logic [31:0] rs);
    int imm;
    imm = int'(ir & 32'h0000_FFFF);
    if (imm >= 32768) imm = imm - 65536;
    case (sel)
      2'd0:    return pc + 32'd1;
      2'd1:    return pc + 32'd1 + 32'(imm);
      2'd2:    return (pc & 32'hFC00_0000) | (ir & 32'h03FF_FFFF);
      default: return rs;
    endcase
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_pc(input logic [1:0] sel, input logic [31:0] rs);
    PC_LOAD = 1'b1;
    NPC_SEL = sel;
    RS_DATA = rs;
    m_pc    = ref_npc(sel, m_pc, m_ir, rs);
    step();
    PC_LOAD = 1'b0;
  endtask

  // Issues one fetch and observes ncyc cycles after it. Cycle 1 is the first
  // cycle after the request edge; MEM_READY is high only in cycle delay+1.
  task automatic run_fetch(input logic [31:0] data, input int delay,
                           input int load_at, input logic [1:0] lsel, input logic [31:0] lrs,
                           input int fetch_at, input int ncyc,
                           output int busy_cnt, output int valid_cnt, output int valid_cyc,
                           output int pc_chg_cyc, output logic [AW-1:0] addr1, output logic rd1);
    logic [31:0] pc0;
    pc0 = m_pc;
    busy_cnt = 0; valid_cnt = 0; valid_cyc = -1; pc_chg_cyc = -1;
    addr1 = '0; rd1 = 1'b0;
    FETCH_REQ = 1'b1;
    MEM_DATA  = data;
    step();
    FETCH_REQ = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      if (BUSY) busy_cnt++;
      if (INST_VALID) begin valid_cnt++; valid_cyc = c; end
      if (PC !== pc0 && pc_chg_cyc < 0) pc_chg_cyc = c;
      if (c == 1) begin addr1 = MEM_ADDR; rd1 = MEM_READ; end
      MEM_READY = (c == delay + 1);
      PC_LOAD   = (c == load_at);
      NPC_SEL   = lsel;
      RS_DATA   = lrs;
      FETCH_REQ = (c == fetch_at);
      step();
    end
    MEM_READY = 1'b0; PC_LOAD = 1'b0; FETCH_REQ = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({MEM_READ, INST_VALID, BUSY, FAULT} !== 4'b0 || MEM_ADDR !== '0) begin
      errors++;
      $display("FAIL reset_ctrl got rd=%b v=%b b=%b f=%b addr=%h exp all zero",
               MEM_READ, INST_VALID, BUSY, FAULT, MEM_ADDR);
    end
    checks++;
    if (PC !== RPC || INSTRUCTION !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs got pc=%h ir=%h exp pc=%h ir=0", PC, INSTRUCTION, RPC);
    end
    @(negedge CLK);
    RST  = 1'b1;
    m_pc = RPC;
    m_ir = 32'h0;
    step();
  endtask

  task automatic test_fetch_basic();
    int b, v, vc, pcc; logic [AW-1:0] a; logic r;
    run_fetch(32'h2002_000A, 0, -1, 2'b00, 32'h0, -1, 4, b, v, vc, pcc, a, r);
    m_ir = 32'h2002_000A;
    checks++;
    if (a !== 26'h000_1000 || r !== 1'b1) begin
      errors++;
      $display("FAIL fetch_addr got addr=%h rd=%b exp addr=0001000 rd=1", a, r);
    end
    checks++;
    if (vc !== 2 || v !== 1) begin
      errors++;
      $display("FAIL fetch_latency got valid_cycle=%0d count=%0d exp 2 and 1", vc, v);
    end
    checks++;
    if (INSTRUCTION !== 32'h2002_000A || PC !== 32'h1000) begin
      errors++;
      $display("FAIL fetch_regs got ir=%h pc=%h exp ir=2002000a pc=1000", INSTRUCTION, PC);
    end
  endtask

  task automatic test_idle_ready();
    int seen;
    seen = 0;
    MEM_READY = 1'b1;
    MEM_DATA  = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      step();
      if (INST_VALID || BUSY) seen++;
    end
    MEM_READY = 1'b0;
    checks++;
    if (seen !== 0 || INSTRUCTION !== m_ir) begin
      errors++;
      $display("FAIL idle_ready got events=%0d ir=%h exp 0 and %h", seen, INSTRUCTION, m_ir);
    end
  endtask

  task automatic test_branch();
    int b, v, vc, pcc; logic [AW-1:0] a; logic r;
    run_fetch(32'h1022_FFFE, 0, -1, 2'b00, 32'h0, -1, 3, b, v, vc, pcc, a, r);
    m_ir = 32'h1022_FFFE;
    load_pc(2'b11, 32'h1004);
    load_pc(2'b01, 32'h0);
    checks++;
    if (PC !== 32'h1003) begin
      errors++;
      $display("FAIL branch_neg got pc=%h exp 00001003", PC);
    end
    load_pc(2'b00, 32'h0);
    checks++;
    if (PC !== 32'h1004) begin
      errors++;
      $display("FAIL pc_inc got pc=%h exp 00001004", PC);
    end
    load_pc(2'b11, 32'hFFFF_FFFF);
    load_pc(2'b00, 32'h0);
    checks++;
    if (PC !== 32'h0) begin
      errors++;
      $display("FAIL pc_wrap got pc=%h exp 00000000", PC);
    end
  endtask

  task automatic test_jump_reg();
    int b, v, vc, pcc; logic [AW-1:0] a; logic r;
    run_fetch(32'h0800_1234, 0, -1, 2'b00, 32'h0, -1, 3, b, v, vc, pcc, a, r);
    m_ir = 32'h0800_1234;
    load_pc(2'b11, 32'h1008);
    load_pc(2'b10, 32'h0);
    checks++;
    if (PC !== 32'h0000_1234) begin
      errors++;
      $display("FAIL jump got pc=%h exp 00001234", PC);
    end
    load_pc(2'b11, 32'h2000);
    checks++;
    if (PC !== 32'h2000) begin
      errors++;
      $display("FAIL jr got pc=%h exp 00002000", PC);
    end
  endtask

  task automatic test_back_to_back();
    // PC_LOAD and FETCH_REQ together: the address must come from the new PC.
    PC_LOAD   = 1'b1;
    FETCH_REQ = 1'b1;
    NPC_SEL   = 2'b11;
    RS_DATA   = 32'h0000_3456;
    m_pc      = 32'h0000_3456;
    step();
    PC_LOAD = 1'b0; FETCH_REQ = 1'b0;
    MEM_READY = 1'b1; MEM_DATA = 32'h0000_0007;
    checks++;
    if (MEM_ADDR !== 26'h000_3456 || PC !== 32'h3456) begin
      errors++;
      $display("FAIL load_and_fetch got addr=%h pc=%h exp 0003456 and 00003456", MEM_ADDR, PC);
    end
    step();
    MEM_READY = 1'b0;
    m_ir = 32'h0000_0007;
    step();
  endtask

  task automatic test_wait_pending();
    int b, v, vc, pcc; logic [AW-1:0] a; logic r;
    logic [31:0] pc0;
    pc0 = m_pc;
    run_fetch(32'h0000_00AA, 5, 2, 2'b00, 32'h0, 3, 10, b, v, vc, pcc, a, r);
    m_ir = 32'h0000_00AA;
    m_pc = pc0 + 32'd1;
    checks++;
    if (b !== 6 || v !== 1) begin
      errors++;
      $display("FAIL wait_busy got busy=%0d valid=%0d exp 6 and 1", b, v);
    end
    checks++;
    if (vc !== 7 || pcc !== 8) begin
      errors++;
      $display("FAIL wait_pending_timing got valid_cyc=%0d pc_cyc=%0d exp 7 and 8", vc, pcc);
    end
    checks++;
    if (PC !== m_pc || INSTRUCTION !== m_ir || BUSY !== 1'b0 || MEM_ADDR !== pc0[AW-1:0]) begin
      errors++;
      $display("FAIL wait_final got pc=%h ir=%h busy=%b addr=%h exp %h %h 0 %h",
               PC, INSTRUCTION, BUSY, MEM_ADDR, m_pc, m_ir, pc0[AW-1:0]);
    end
  endtask

  task automatic test_random();
    int b, v, vc, pcc, op, dly, lat; logic [AW-1:0] a; logic r;
    logic [1:0] sel; logic [31:0] rs, data, pc0;
    for (int i = 0; i < 30; i++) begin
      op   = $urandom_range(0, 2);
      sel  = 2'($urandom_range(0, 3));
      rs   = $urandom;
      data = $urandom;
      dly  = $urandom_range(0, 4);
      pc0  = m_pc;
      if (op == 0) begin
        load_pc(sel, rs);
        checks++;
        if (PC !== m_pc) begin
          errors++;
          $display("FAIL rand_load[%0d] sel=%0d got pc=%h exp %h", i, sel, PC, m_pc);
        end
      end else begin
        lat = (op == 2) ? $urandom_range(1, dly + 1) : -1;
        run_fetch(data, dly, lat, sel, rs, -1, dly + 4, b, v, vc, pcc, a, r);
        m_ir = data;
        if (op == 2) m_pc = ref_npc(sel, pc0, data, rs);
        checks++;
        if (PC !== m_pc || INSTRUCTION !== m_ir || a !== pc0[AW-1:0] ||
            b !== dly + 1 || v !== 1 || vc !== dly + 2) begin
          errors++;
          $display("FAIL rand_fetch[%0d] got pc=%h ir=%h addr=%h busy=%0d valid=%0d@%0d exp %h %h %h %0d 1@%0d",
                   i, PC, INSTRUCTION, a, b, v, vc, m_pc, m_ir, pc0[AW-1:0], dly + 1, dly + 2);
        end
        if (op == 2 && m_pc !== pc0) begin
          checks++;
          if (pcc !== dly + 3) begin
            errors++;
            $display("FAIL rand_pending_cyc[%0d] got %0d exp %0d", i, pcc, dly + 3);
          end
        end
      end
    end
  endtask

  task automatic test_timeout();
    int b, v, vc, pcc; logic [AW-1:0] a; logic r;
    run_fetch(32'h1111_2222, 1000, -1, 2'b00, 32'h0, -1, TO + 3, b, v, vc, pcc, a, r);
    checks++;
    if (b !== TO || v !== 0) begin
      errors++;
      $display("FAIL timeout_busy got busy=%0d valid=%0d exp %0d and 0", b, v, TO);
    end
    checks++;
    if (FAULT !== 1'b1 || MEM_READ !== 1'b0 || INSTRUCTION !== m_ir) begin
      errors++;
      $display("FAIL timeout_state got fault=%b rd=%b ir=%h exp 1 0 %h", FAULT, MEM_READ, INSTRUCTION, m_ir);
    end
    run_fetch(32'h3333_4444, 0, 1, 2'b11, 32'h5555_0000, -1, 4, b, v, vc, pcc, a, r);
    checks++;
    if (b !== 0 || v !== 0 || FAULT !== 1'b1 || PC !== m_pc || INSTRUCTION !== m_ir) begin
      errors++;
      $display("FAIL fault_absorb got busy=%0d valid=%0d fault=%b pc=%h ir=%h exp 0 0 1 %h %h",
               b, v, FAULT, PC, INSTRUCTION, m_pc, m_ir);
    end
    #2;
    RST = 1'b0;
    #1;
    checks++;
    if (FAULT !== 1'b0 || PC !== RPC) begin
      errors++;
      $display("FAIL fault_reset got fault=%b pc=%h exp 0 %h", FAULT, PC, RPC);
    end
    m_pc = RPC; m_ir = 32'h0;
    @(negedge CLK);
    RST = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_wait();
    int seen;
    load_pc(2'b11, 32'h0000_4000);
    FETCH_REQ = 1'b1;
    step();
    FETCH_REQ = 1'b0;
    PC_LOAD = 1'b1; NPC_SEL = 2'b11; RS_DATA = 32'h0000_9999;
    step();
    PC_LOAD = 1'b0;
    #2;
    RST = 1'b0;
    #1;
    checks++;
    if (MEM_READ !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_async got rd=%b busy=%b exp 0 0", MEM_READ, BUSY);
    end
    m_pc = RPC; m_ir = 32'h0;
    step();
    @(negedge CLK);
    RST = 1'b1;
    MEM_READY = 1'b1;
    MEM_DATA  = 32'hCAFE_F00D;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (INST_VALID || BUSY) seen++;
    end
    MEM_READY = 1'b0;
    checks++;
    if (seen !== 0 || INSTRUCTION !== m_ir || PC !== m_pc) begin
      errors++;
      $display("FAIL reset_mid_wait got events=%0d ir=%h pc=%h exp 0 %h %h", seen, INSTRUCTION, PC, m_ir, m_pc);
    end
  endtask

  initial begin
    test_reset();
    test_fetch_basic();
    test_idle_ready();
    test_branch();
    test_jump_reg();
    test_back_to_back();
    test_wait_pending();
    test_random();
    test_timeout();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
